// File: rtl/zxn_bram_sweep_ctrl.sv
// On-chip RAM controller for the ZX Next core: block RAM with a fill-value clear
// sweep (reset and region clears with wrap-around) and a req/ack host port.
module zxn_bram_sweep_ctrl #(
  parameter int unsigned        DATA_W       = 8,
  parameter int unsigned        DEPTH        = 409600,
  parameter int unsigned        ADDR_W       = 21,
  parameter logic [DATA_W-1:0]  FILL         = '1,
  parameter bit                 CLR_ON_RESET = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              clr_start,
  input  logic [ADDR_W-1:0] clr_base,
  input  logic [ADDR_W-1:0] clr_last,
  output logic              busy,
  output logic              clr_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last;
  logic              init_pend;
  logic              clr_ok;
  logic              host_addr_ok;

  logic [DATA_W-1:0] ram [DEPTH];

  // Out-of-range clear requests are dropped entirely.
  assign clr_ok       = clr_start & ({1'b0, clr_base} < DEPTH_V) & ({1'b0, clr_last} < DEPTH_V);
  assign host_addr_ok = ({1'b0, host_addr} < DEPTH_V);
  assign host_ack     = host_req & (state == IDLE) & ~clr_start;

  // Sweep FSM; a new clear request restarts any sweep in flight.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      clr_done  <= 1'b0;
      ptr       <= '0;
      last      <= '0;
      init_pend <= CLR_ON_RESET;
    end else begin
      clr_done  <= 1'b0;
      init_pend <= 1'b0;
      if (clr_ok) begin
        ptr   <= clr_base;
        last  <= clr_last;
        state <= CLEAR;
        busy  <= 1'b1;
      end else if (init_pend) begin
        ptr   <= '0;
        last  <= LAST_ADDR;
        state <= CLEAR;
        busy  <= 1'b1;
      end else if (state == CLEAR) begin
        if (ptr == last) begin
          state    <= IDLE;
          busy     <= 1'b0;
          clr_done <= 1'b1;
        end else begin
          ptr <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
        end
      end
    end
  end

  // Registered read port; out-of-range reads return the fill word.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_ack & ~host_we;
      if (host_ack && !host_we) begin
        host_rdata <= host_addr_ok ? ram[IDX_W'(host_addr)] : FILL;
      end
    end
  end

  // Single write port: the sweep owns it in CLEAR, except on a restart edge.
  always_ff @(posedge clk_sys) begin
    if (state == CLEAR && !clr_ok) begin
      ram[IDX_W'(ptr)] <= FILL;
    end else if (host_ack && host_we && host_addr_ok) begin
      ram[IDX_W'(host_addr)] <= host_din;
    end
  end

endmodule

// File: tb/tb_zxn_bram_sweep_ctrl.sv
// Directed bench for zxn_bram_sweep_ctrl with a 16-word, 8-bit, fill 8'hFF instance.
module tb_zxn_bram_sweep_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 5;
  localparam logic [7:0]  FILLV  = 8'hFF;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              clr_start;
  logic [ADDR_W-1:0] clr_base;
  logic [ADDR_W-1:0] clr_last;
  logic              busy;
  logic              clr_done;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  int total = 0;
  int bad   = 0;

  zxn_bram_sweep_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL(FILLV), .CLR_ON_RESET(1'b1)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .clr_start(clr_start), .clr_base(clr_base), .clr_last(clr_last),
    .busy(busy), .clr_done(clr_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    host_req  = 1'b1;
    host_we   = 1'b1;
    host_addr = ADDR_W'(addr);
    host_din  = data;
    #1;
    check($sformatf("wr_ack[%0d]", addr), 32'(host_ack), 32'd1);
    step();
    host_req = 1'b0;
    host_we  = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [7:0] exp);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = ADDR_W'(addr);
    #1;
    check($sformatf("rd_ack[%0d]", addr), 32'(host_ack), 32'd1);
    step();
    host_req = 1'b0;
    check($sformatf("rvalid[%0d]", addr), 32'(host_rvalid), 32'd1);
    check($sformatf("rdata[%0d]", addr), 32'(host_rdata), 32'(exp));
  endtask

  task automatic sweep_count(input int maxc, output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int i = 0; i < maxc; i++) begin
      if (busy) nb++;
      if (clr_done) nd++;
      step();
    end
  endtask

  task automatic start_clear(input int base, input int last);
    clr_start = 1'b1;
    clr_base  = ADDR_W'(base);
    clr_last  = ADDR_W'(last);
    step();
    clr_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, waits;
    bit got;
    reset_n = 1'b0; clr_start = 1'b0; clr_base = '0; clr_last = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;

    // 1: reset values, automatic full sweep, everything reads as fill
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(clr_done), 32'd0);
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_rdata", 32'(host_rdata), 32'd0);
    step();
    reset_n = 1'b1;
    sweep_count(24, nb, nd);
    check("init_busy_cycles", 32'(nb), 32'd16);
    check("init_done_pulses", 32'(nd), 32'd1);
    for (int a = 0; a < 16; a++) rd(a, FILLV);

    // 2: write then read back
    wr(3, 8'hA5);
    check("wr_no_rvalid", 32'(host_rvalid), 32'd0);
    rd(3, 8'hA5);

    // 3: wrap-around region clear
    for (int a = 0; a < 16; a++) wr(a, 8'h00);
    start_clear(14, 1);
    sweep_count(10, nb, nd);
    check("wrap_busy_cycles", 32'(nb), 32'd4);
    check("wrap_done_pulses", 32'(nd), 32'd1);
    for (int a = 0; a < 16; a++) rd(a, (a >= 14 || a <= 1) ? FILLV : 8'h00);

    // out-of-range region is ignored
    start_clear(16, 2);
    check("bad_range_busy", 32'(busy), 32'd0);
    rd(2, 8'h00);

    // 4: host read held off by a sweep
    start_clear(0, 15);
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd5;
    waits = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      #1;
      if (host_ack) got = 1'b1;
      else begin
        waits++;
        step();
      end
    end
    check("held_ack_seen", 32'(got), 32'd1);
    check("held_wait_cycles", 32'(waits), 32'd16);
    check("held_busy_at_ack", 32'(busy), 32'd0);
    check("held_done_at_ack", 32'(clr_done), 32'd1);
    step();
    host_req = 1'b0;
    check("held_rvalid", 32'(host_rvalid), 32'd1);
    check("held_rdata", 32'(host_rdata), 32'hFF);

    // 5: restart a sweep mid-flight
    for (int a = 0; a < 16; a++) wr(a, 8'h00);
    start_clear(0, 15);
    step();
    step();
    start_clear(8, 9);
    check("rs_busy0", 32'(busy), 32'd1);
    check("rs_done0", 32'(clr_done), 32'd0);
    step();
    check("rs_busy1", 32'(busy), 32'd1);
    check("rs_done1", 32'(clr_done), 32'd0);
    step();
    check("rs_busy2", 32'(busy), 32'd0);
    check("rs_done2", 32'(clr_done), 32'd1);
    step();
    check("rs_done3", 32'(clr_done), 32'd0);
    for (int a = 0; a < 16; a++) rd(a, (a <= 1 || a == 8 || a == 9) ? FILLV : 8'h00);

    // 6: reset mid-sweep, then the full sweep reruns
    start_clear(0, 15);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rvalid", 32'(host_rvalid), 32'd0);
    check("mid_rst_done", 32'(clr_done), 32'd0);
    step();
    reset_n = 1'b1;
    sweep_count(24, nb, nd);
    check("rerun_busy_cycles", 32'(nb), 32'd16);
    check("rerun_done_pulses", 32'(nd), 32'd1);
    rd(20, FILLV);
    rd(7, FILLV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
